// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helper function for the register file
package regfile_pkg;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 8;

  // Ceiling log2 for tools lacking $clog2; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - combinational N:1 word selector, out-of-range select yields zero
module mux_nto1 #(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]  sel,
  input  logic [N*WIDTH-1:0] in,
  output logic [WIDTH-1:0]   out
);

  // Pick the matching word; no match (select beyond N-1) leaves the zero default.
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == ADDR_W'(i)) begin
        out = in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mrw.sv
// rtl/regfile_mrw.sv - flop register file, one write port, two registered read ports with bypass
module regfile_mrw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DEPTH*WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]       mux_a;
  logic [WIDTH-1:0]       mux_b;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       sel_b;
  logic                   ok_a;
  logic                   ok_b;

  // Register storage: clear wins over write; out-of-range and hardwired-zero writes fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (clr) begin
      mem_q <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i) && !(ZR && i == 0)) begin
          mem_q[i*WIDTH +: WIDTH] <= wdata;
        end
      end
    end
  end

  mux_nto1 #(.N(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mux_a (
    .sel (raddr_a),
    .in  (mem_q),
    .out (mux_a)
  );

  mux_nto1 #(.N(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mux_b (
    .sel (raddr_b),
    .in  (mem_q),
    .out (mux_b)
  );

  // A power-of-two depth makes every address legal, so skip the compare entirely.
  if ((1 << ADDR_W) == DEPTH) begin : g_full_range
    assign ok_a = 1'b1;
    assign ok_b = 1'b1;
  end else begin : g_part_range
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    assign ok_a = (raddr_a <= LAST);
    assign ok_b = (raddr_b <= LAST);
  end

  // Read-side priority: range, hardwired zero, same-cycle clear, same-cycle write, stored word.
  function automatic logic [WIDTH-1:0] pick(
    input logic              ok,
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              c,
    input logic              w,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    if (!ok)                   return '0;
    if (ZR && addr == '0)      return '0;
    if (c)                     return '0;
    if (w && wa == addr)       return wd;
    return stored;
  endfunction

  assign sel_a = pick(ok_a, raddr_a, mux_a, clr, we, waddr, wdata);
  assign sel_b = pick(ok_b, raddr_b, mux_b, clr, we, waddr, wdata);

  // Port A output register: data loads only on a request, valid is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      if (re_a) begin
        rdata_a <= sel_a;
      end
    end
  end

  // Port B output register, independent of port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_b <= re_b;
      if (re_b) begin
        rdata_b <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mrw.sv
// tb/tb_regfile_mrw.sv - scoreboard bench for regfile_mrw in three parameter builds
`timescale 1ns/1ps
module tb_regfile_mrw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        we;
  logic [2:0]  waddr;
  logic [11:0] wdata;
  logic [2:0]  re_a;
  logic [2:0]  re_b;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;

  logic [7:0]  rdata_a0, rdata_b0, rdata_az, rdata_bz;
  logic [11:0] rdata_ad, rdata_bd;
  logic        rvalid_a0, rvalid_b0, rvalid_az, rvalid_bz, rvalid_ad, rvalid_bd;

  int n_checks = 0;
  int n_err    = 0;

  // Queue index = build*2 + port (build 0 default, 1 zero-reg, 2 depth5/width12; port 0 A, 1 B).
  logic [11:0] q [6][$];
  logic [5:0]  rv;
  logic [11:0] rd [6];

  // Reference model storage, one row per build.
  logic [11:0] mdl [3][8];

  always #5 clk = ~clk;

  regfile_mrw #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .re_a(re_a[0]), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b[0]), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0)
  );

  regfile_mrw #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_dutz (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .re_a(re_a[1]), .raddr_a(raddr_a), .rdata_a(rdata_az), .rvalid_a(rvalid_az),
    .re_b(re_b[1]), .raddr_b(raddr_b), .rdata_b(rdata_bz), .rvalid_b(rvalid_bz)
  );

  regfile_mrw #(.WIDTH(12), .DEPTH(5), .ZERO_REG(0)) u_dutd (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a[2]), .raddr_a(raddr_a), .rdata_a(rdata_ad), .rvalid_a(rvalid_ad),
    .re_b(re_b[2]), .raddr_b(raddr_b), .rdata_b(rdata_bd), .rvalid_b(rvalid_bd)
  );

  assign rv = {rvalid_bd, rvalid_ad, rvalid_bz, rvalid_az, rvalid_b0, rvalid_a0};
  assign rd[0] = {4'h0, rdata_a0};
  assign rd[1] = {4'h0, rdata_b0};
  assign rd[2] = {4'h0, rdata_az};
  assign rd[3] = {4'h0, rdata_bz};
  assign rd[4] = rdata_ad;
  assign rd[5] = rdata_bd;

  function automatic void chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every valid strobe pops the oldest expectation for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 6; p++) begin
        if (rv[p]) begin
          if (q[p].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_rvalid q%0d: got rvalid=1 with data %h, expected no strobe", p, rd[p]);
          end else begin
            chk($sformatf("rdata_q%0d", p), rd[p], q[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus at a negedge and hold it until the next negedge.
  task automatic drive(input logic c, input logic w, input logic [2:0] wa, input logic [11:0] wd,
                       input logic [2:0] rea, input logic [2:0] aa,
                       input logic [2:0] reb, input logic [2:0] ab);
    clr = c; we = w; waddr = wa; wdata = wd;
    re_a = rea; raddr_a = aa; re_b = reb; raddr_b = ab;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b000, 3'd0, 3'b000, 3'd0);
  endtask

  function automatic int mdl_depth(input int cfg);
    return (cfg == 2) ? 5 : 8;
  endfunction

  function automatic logic [11:0] mdl_mask(input int cfg);
    return (cfg == 2) ? 12'hFFF : 12'h0FF;
  endfunction

  function automatic logic [11:0] mdl_sel(input int cfg, input logic [2:0] a);
    if (int'(a) >= mdl_depth(cfg)) return 12'h000;
    if (cfg == 1 && a == 3'd0)     return 12'h000;
    if (clr)                       return 12'h000;
    if (we && waddr == a)          return wdata & mdl_mask(cfg);
    return mdl[cfg][a];
  endfunction

  function automatic void mdl_update(input int cfg);
    if (clr) begin
      for (int k = 0; k < 8; k++) mdl[cfg][k] = 12'h000;
    end else if (we && int'(waddr) < mdl_depth(cfg) && !(cfg == 1 && waddr == 3'd0)) begin
      mdl[cfg][waddr] = wdata & mdl_mask(cfg);
    end
  endfunction

  initial begin
    logic       c, w;
    logic [2:0] wa, aa, ab, rea, reb;
    logic [11:0] wd;

    // Reset held while a write is presented: nothing may be stored.
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b1; wdata = 12'h0FF; waddr = 3'd0;
    re_a = 3'b000; re_b = 3'b000; raddr_a = 3'd0; raddr_b = 3'd0;
    for (int i = 0; i < 3; i++) begin
      waddr = 3'(i);
      @(negedge clk);
    end
    chk("reset_rvalid_a", {11'h0, rvalid_a0}, 12'h000);
    chk("reset_rdata_a", {4'h0, rdata_a0}, 12'h000);
    we = 1'b0;
    rst_n = 1'b1;

    // Test 1: every address reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(12'h000);
      drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b001, 3'(i), 3'b000, 3'd0);
    end

    // Test 1b: asynchronous reset kills an in-flight valid without a clock edge.
    re_a = 3'b001; raddr_a = 3'd0;
    @(posedge clk);
    #1;
    chk("pre_reset_rvalid_a", {11'h0, rvalid_a0}, 12'h001);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_rvalid_a", {11'h0, rvalid_a0}, 12'h000);
    @(negedge clk);
    re_a = 3'b000;
    rst_n = 1'b1;

    // Test 2: write sweep then crossed reads on both ports.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 12'h0A0 + 12'(i), 3'b000, 3'd0, 3'b000, 3'd0);
    end
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(12'h0A0 + 12'(i));
      q[1].push_back(12'h0A7 - 12'(i));
      drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b001, 3'(i), 3'b001, 3'(7 - i));
    end

    // Test 3: same-cycle write is visible to the read, then persists.
    drive(1'b0, 1'b1, 3'd3, 12'h011, 3'b000, 3'd0, 3'b000, 3'd0);
    q[0].push_back(12'h05C);
    drive(1'b0, 1'b1, 3'd3, 12'h05C, 3'b001, 3'd3, 3'b000, 3'd0);
    q[0].push_back(12'h05C);
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b001, 3'd3, 3'b000, 3'd0);

    // Test 4: clear beats a concurrent write and its bypass; all registers empty afterwards.
    q[1].push_back(12'h000);
    drive(1'b1, 1'b1, 3'd2, 12'h077, 3'b000, 3'd0, 3'b001, 3'd2);
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(12'h000);
      q[1].push_back(12'h000);
      drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b001, 3'(i), 3'b001, 3'(7 - i));
    end

    // Test 5: hardwired-zero build ignores writes and bypass on register 0 only.
    drive(1'b0, 1'b1, 3'd0, 12'h03C, 3'b000, 3'd0, 3'b000, 3'd0);
    q[2].push_back(12'h000);
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b010, 3'd0, 3'b000, 3'd0);
    q[2].push_back(12'h000);
    drive(1'b0, 1'b1, 3'd0, 12'h03C, 3'b010, 3'd0, 3'b000, 3'd0);
    q[2].push_back(12'h03C);
    drive(1'b0, 1'b1, 3'd1, 12'h03C, 3'b010, 3'd1, 3'b000, 3'd0);
    q[3].push_back(12'h03C);
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b000, 3'd0, 3'b010, 3'd1);

    // Test 6: non-power-of-two depth, wider words, out-of-range accesses.
    drive(1'b0, 1'b1, 3'd6, 12'hABC, 3'b000, 3'd0, 3'b000, 3'd0);
    q[4].push_back(12'h000);
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b100, 3'd6, 3'b000, 3'd0);
    q[4].push_back(12'h000);
    q[5].push_back(12'h000);
    drive(1'b0, 1'b1, 3'd6, 12'hABC, 3'b100, 3'd6, 3'b100, 3'd7);
    drive(1'b0, 1'b1, 3'd4, 12'h123, 3'b000, 3'd0, 3'b000, 3'd0);
    q[4].push_back(12'h123);
    drive(1'b0, 1'b0, 3'd0, 12'h000, 3'b100, 3'd4, 3'b000, 3'd0);

    // Randomised run on all three builds; the first cycle clears to sync the model.
    for (int cfg = 0; cfg < 3; cfg++)
      for (int k = 0; k < 8; k++) mdl[cfg][k] = 12'h000;
    for (int i = 0; i < 2000; i++) begin
      c   = (i == 0) ? 1'b1 : ($urandom_range(31) == 0);
      w   = 1'($urandom_range(1));
      wa  = 3'($urandom_range(7));
      wd  = 12'($urandom_range(12'hFFF));
      rea = 3'($urandom_range(7));
      reb = 3'($urandom_range(7));
      aa  = 3'($urandom_range(7));
      ab  = 3'($urandom_range(7));
      clr = c; we = w; waddr = wa; wdata = wd;
      for (int cfg = 0; cfg < 3; cfg++) begin
        if (rea[cfg]) q[cfg*2].push_back(mdl_sel(cfg, aa));
        if (reb[cfg]) q[cfg*2+1].push_back(mdl_sel(cfg, ab));
        mdl_update(cfg);
      end
      drive(c, w, wa, wd, rea, aa, reb, ab);
    end

    idle();
    idle();
    idle();
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("drained_q%0d", p), 12'(q[p].size()), 12'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mrw.md
Name: regfile_mrw

Overview:
- Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port, two independent registered read ports.
- Each read port selects through a parametrised N:1 multiplexer, the generalisation of the 8:1 select mux.
- Adds what a purely combinational selector lacks:
  - registered reads with a valid strobe;
  - write-to-read bypass;
  - optional hardwired-zero register 0;
  - synchronous bulk clear.
- Sits in the Eight-Register Register File datapath as the operand store feeding the ALU, A and B ports.

Parameters:
- WIDTH, 8: bits per register, 1..64.
- DEPTH, 8: number of registers, 2..64, need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.
- ZERO_REG, 0: when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all registers; takes priority over write.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- re_a  in  1  read request, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  WIDTH  registered read data, port A.
- rvalid_a  out  1  rdata_a valid, one cycle after re_a.
- re_b, raddr_b, rdata_b, rvalid_b: identical to the A-port signals, for port B.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - rst_n low clears all registers, rdata_a/b and rvalid_a/b to 0 immediately, with no clock required.
  - On deassertion the block is idle; the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On a rising edge with we=1, clr=0 and waddr<DEPTH, mem[waddr] <= wdata.
  - waddr>=DEPTH: write ignored, no side effects.
  - ZERO_REG=1 and waddr=0: write ignored.
- Clear: on a rising edge with clr=1, all registers <= 0. A concurrent we is discarded.
- Read latency is 1 cycle.
  - On a rising edge with re_x=1, rdata_x <= sel(raddr_x) and rvalid_x <= 1.
  - With re_x=0: rvalid_x <= 0 and rdata_x holds its previous value.
- sel(addr), in priority order:
  1. 0 if addr>=DEPTH.
  2. 0 if ZERO_REG=1 and addr=0.
  3. 0 if clr=1 in that same cycle.
  4. wdata if we=1 and waddr=addr (bypass: same-cycle write is visible).
  5. mem[addr] otherwise.
- Simultaneous events:
  - Both ports may read the same address in the same cycle, each independently.
  - Read and write to different addresses do not interact.
  - Back-to-back writes to one address: the last write wins.
- rvalid is a strobe, not a handshake. There is no backpressure; the consumer must sample in the cycle rvalid is high.
- Reset asserted mid-operation: any in-flight read is dropped and rvalid is forced to 0. No partial write survives.
- No latches. Storage is flops only, no RAM inference required. Arithmetic widths: comparisons are on ADDR_W bits only.

Decomposition:
- Package regfile_pkg holds:
  - function clog2 (for tools lacking $clog2);
  - localparam defaults RF_WIDTH=8 and RF_DEPTH=8.
- Sub-module mux_nto1 (parameters N, WIDTH; ports sel[ADDR_W-1:0], in[N*WIDTH-1:0], out[WIDTH-1:0]):
  - purely combinational;
  - out of range returns 0;
  - instantiated once per read port.
- Bypass and zero-forcing live in regfile_mrw around the mux output.

Test Plan:
1. Reset: hold rst_n=0 with we=1, wdata=8'hFF; release, then read all 8 addresses on port A -> every rdata_a=8'h00. Assert rst_n=0 mid-cycle -> rvalid_a drops to 0 without a clock edge.
2. Write/read sweep: write mem[i]=8'hA0+i for i=0..7, then read A=i and B=7-i each cycle -> rdata_a=8'hA0+i and rdata_b=8'hA7-i, one cycle after re, with rvalid high exactly that cycle.
3. Bypass: mem[3]=8'h11; in one cycle we=1, waddr=3, wdata=8'h5C, re_a=1, raddr_a=3 -> next cycle rdata_a=8'h5C. Read mem[3] again -> 8'h5C.
4. Clear priority: clr=1 with we=1, waddr=2, wdata=8'h77, and re_b=1 at address 2 in the same cycle -> rdata_b=8'h00. Every register then reads 8'h00.
5. ZERO_REG=1 build: write 8'h3C to address 0 -> read returns 8'h00. The same-cycle bypass read of address 0 also returns 8'h00.
6. DEPTH=5, WIDTH=12 build:
   - Write 12'hABC to address 6 -> ignored.
   - Read address 6 -> 12'h000.
   - Read address 4 after writing 12'h123 -> 12'h123.
   - Randomised 2000-cycle run against a reference model -> zero mismatches.
